// File: rtl/cam_cap_pkg.sv
// cam_cap_pkg: shared encodings, FSM states and byte-pair unpacking for the camera capture engine.
package cam_cap_pkg;
   typedef enum logic [1:0] {FMT_444 = 2'd0, FMT_565 = 2'd1, FMT_Y = 2'd2, FMT_RSV = 2'd3} fmt_e;
   typedef enum logic [1:0] {DEC_1 = 2'd0, DEC_2 = 2'd1, DEC_4 = 2'd2, DEC_4B = 2'd3} decim_e;
   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CAPTURE = 2'd2} state_e;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb8_t;
   // Channels come back MSB-aligned in 8 bits so any output width is a plain top-bit slice.
   function automatic rgb8_t unpack_rgb8(input fmt_e f, input logic [7:0] b0, input logic [7:0] b1);
      rgb8_t p;
      p = '0;
      case (f)
         FMT_444: p = {b0[3:0], 4'h0, b1[7:4], 4'h0, b1[3:0], 4'h0};
         FMT_565: p = {b0[7:3], 3'h0, b0[2:0], b1[7:5], 2'h0, b1[4:0], 3'h0};
         FMT_Y:   p = {b0, b0, b0};
         default: p = '0;
      endcase
      return p;
   endfunction
   function automatic logic [1:0] decim_shift(input decim_e d);
      return (d == DEC_1) ? 2'd0 : (d == DEC_2) ? 2'd1 : 2'd2;
   endfunction
endpackage

// File: rtl/cam_pix_pack.sv
// cam_pix_pack: combinational byte pair plus format to CW-bit-per-channel RGB word.
module cam_pix_pack
   import cam_cap_pkg::*;
#(
   parameter int CW = 4
) (
   input  fmt_e            fmt_i,
   input  logic [7:0]      b0_i,
   input  logic [7:0]      b1_i,
   output logic [3*CW-1:0] rgb_o
);
   rgb8_t p;
   logic  unused_lsb;
   assign p          = unpack_rgb8(fmt_i, b0_i, b1_i);
   assign rgb_o      = {p.r[7 -: CW], p.g[7 -: CW], p.b[7 -: CW]};
   assign unused_lsb = ^{p.r[7-CW:0], p.g[7-CW:0], p.b[7-CW:0]};
endmodule

// File: rtl/cam_capture_win.sv
// cam_capture_win: camera byte stream to VRAM port A with runtime crop window, decimation and frame control.
module cam_capture_win
   import cam_cap_pkg::*;
#(
   parameter int AW_H  = 7,
   parameter int AW_V  = 7,
   parameter int CW    = 4,
   parameter int CNT_W = 12
) (
   input  logic                 pclk,
   input  logic                 rstb,
   input  logic                 c_vsync,
   input  logic                 href,
   input  logic [7:0]           data,
   input  logic [1:0]           fmt,
   input  logic [1:0]           decim,
   input  logic [CNT_W-1:0]     v_start,
   input  logic [CNT_W-1:0]     h_start,
   input  logic [AW_H:0]        out_w,
   input  logic [AW_V:0]        out_h,
   input  logic                 cont_en,
   input  logic                 cap_req,
   output logic                 cap_busy,
   output logic                 cap_done,
   output logic [7:0]           frame_cnt,
   output logic                 phase_err,
   output logic                 wea,
   output logic [AW_V+AW_H-1:0] addra,
   output logic [3*CW-1:0]      dina
);
   logic                 vs1_q, vs2_q, hr1_q, hr2_q, ph_q, ph_d;
   logic [7:0]           dat1_q, b0_q;
   logic [CNT_W-1:0]     px_q, px_d, ln_q, ln_d, vst_q, vst_d, hst_q, hst_d;
   state_e               st_q, st_d;
   fmt_e                 fmt_q, fmt_d;
   decim_e               dec_q, dec_d;
   logic [AW_H:0]        w_q, w_d;
   logic [AW_V:0]        h_q, h_d;
   logic [7:0]           fc_q, fc_d;
   logic                 done_q, done_d, perr_q, perr_d, wea_q, wea_d;
   logic [AW_V+AW_H-1:0] addr_q, addr_d;
   logic [3*CW-1:0]      din_q, din_d, rgb;
   logic                 vs_rise, line_end, pix_done, hit;
   logic [CNT_W-1:0]     dx, dy, col, row;
   logic [1:0]           sh;
   assign vs_rise  = vs1_q & ~vs2_q;
   assign line_end = ~hr1_q & hr2_q;
   assign pix_done = hr1_q & ph_q;
   assign sh       = decim_shift(dec_q);
   assign dx       = px_q - hst_q;
   assign dy       = ln_q - vst_q;
   assign col      = dx >> sh;
   assign row      = dy >> sh;
   // A completing pixel lands only if it sits on the decimation grid inside the cropped window.
   assign hit = (st_q == CAPTURE) && !vs_rise && pix_done && (px_q >= hst_q) && (ln_q >= vst_q)
              && (((dx | dy) & ~({CNT_W{1'b1}} << sh)) == '0)
              && (col < CNT_W'(w_q)) && (row < CNT_W'(h_q));
   cam_pix_pack #(.CW(CW)) u_pack (
      .fmt_i (fmt_q),
      .b0_i  (b0_q),
      .b1_i  (dat1_q),
      .rgb_o (rgb)
   );
   always_comb begin
      st_d   = st_q;
      fmt_d  = fmt_q;
      dec_d  = dec_q;
      vst_d  = vst_q;
      hst_d  = hst_q;
      w_d    = w_q;
      h_d    = h_q;
      fc_d   = fc_q;
      done_d = 1'b0;
      perr_d = perr_q;
      ph_d   = hr1_q ? ~ph_q : ph_q;
      px_d   = (pix_done && px_q != '1) ? px_q + CNT_W'(1) : px_q;
      ln_d   = ln_q;
      wea_d  = hit;
      addr_d = hit ? {row[AW_V-1:0], col[AW_H-1:0]} : addr_q;
      din_d  = hit ? rgb : din_q;
      if (line_end) begin
         ph_d = 1'b0;
         px_d = '0;
         ln_d = (ln_q != '1) ? ln_q + CNT_W'(1) : ln_q;
         if (ph_q && st_q == CAPTURE) perr_d = 1'b1;
      end
      if (vs_rise) begin
         ph_d = 1'b0;
         px_d = '0;
         ln_d = '0;
      end
      if (st_q == IDLE && cap_req) begin
         st_d   = ARM;
         perr_d = 1'b0;
      end
      if (vs_rise && st_q != IDLE) begin
         fc_d   = (st_q == CAPTURE) ? fc_q + 8'd1 : fc_q;
         done_d = (st_q == CAPTURE) && !cont_en;
         st_d   = (st_q == ARM || cont_en) ? CAPTURE : IDLE;
         if (st_d == CAPTURE) begin
            fmt_d = fmt_e'(fmt);
            dec_d = decim_e'(decim);
            vst_d = v_start;
            hst_d = h_start;
            w_d   = out_w;
            h_d   = out_h;
         end
      end
   end
   always_ff @(posedge pclk or negedge rstb) begin
      if (!rstb) begin
         {vs1_q, vs2_q, hr1_q, hr2_q, ph_q} <= '0;
         dat1_q <= '0;
         b0_q   <= '0;
         px_q   <= '0;
         ln_q   <= '0;
         st_q   <= IDLE;
         fmt_q  <= FMT_444;
         dec_q  <= DEC_1;
         vst_q  <= '0;
         hst_q  <= '0;
         w_q    <= '0;
         h_q    <= '0;
         fc_q   <= '0;
         done_q <= 1'b0;
         perr_q <= 1'b0;
         wea_q  <= 1'b0;
         addr_q <= '0;
         din_q  <= '0;
      end else begin
         vs1_q  <= c_vsync;
         vs2_q  <= vs1_q;
         hr1_q  <= href;
         hr2_q  <= hr1_q;
         dat1_q <= data;
         if (hr1_q && !ph_q) b0_q <= dat1_q;
         ph_q   <= ph_d;
         px_q   <= px_d;
         ln_q   <= ln_d;
         st_q   <= st_d;
         fmt_q  <= fmt_d;
         dec_q  <= dec_d;
         vst_q  <= vst_d;
         hst_q  <= hst_d;
         w_q    <= w_d;
         h_q    <= h_d;
         fc_q   <= fc_d;
         done_q <= done_d;
         perr_q <= perr_d;
         wea_q  <= wea_d;
         addr_q <= addr_d;
         din_q  <= din_d;
      end
   end
   assign cap_busy  = (st_q != IDLE);
   assign cap_done  = done_q;
   assign frame_cnt = fc_q;
   assign phase_err = perr_q;
   assign wea       = wea_q;
   assign addra     = addr_q;
   assign dina      = din_q;
endmodule

// File: tb/tb_cam_capture_win.sv
// tb_cam_capture_win: directed scenario bench for the camera capture window engine.
module tb_cam_capture_win;
   localparam int AW_H = 7, AW_V = 7, CW = 4, CNT_W = 12;
   localparam int EW = AW_V + AW_H + 3*CW;
   logic                 pclk = 1'b0, rstb = 1'b0, c_vsync = 1'b0, href = 1'b0, cont_en = 1'b0, cap_req = 1'b0;
   logic [7:0]           data = '0;
   logic [1:0]           fmt = '0, decim = '0;
   logic [CNT_W-1:0]     v_start = '0, h_start = '0;
   logic [AW_H:0]        out_w = '0;
   logic [AW_V:0]        out_h = '0;
   logic                 cap_busy, cap_done, phase_err, wea;
   logic [7:0]           frame_cnt;
   logic [AW_V+AW_H-1:0] addra;
   logic [3*CW-1:0]      dina;
   int                   checks = 0, errors = 0, done_cnt = 0, exp_fc = 0;
   logic [EW-1:0]        wq[$];
   always #5 pclk = ~pclk;
   cam_capture_win #(.AW_H(AW_H), .AW_V(AW_V), .CW(CW), .CNT_W(CNT_W)) dut (
      .pclk(pclk), .rstb(rstb), .c_vsync(c_vsync), .href(href), .data(data), .fmt(fmt), .decim(decim),
      .v_start(v_start), .h_start(h_start), .out_w(out_w), .out_h(out_h), .cont_en(cont_en),
      .cap_req(cap_req), .cap_busy(cap_busy), .cap_done(cap_done), .frame_cnt(frame_cnt),
      .phase_err(phase_err), .wea(wea), .addra(addra), .dina(dina)
   );
   always @(negedge pclk) begin
      if (wea) wq.push_back({addra, dina});
      if (cap_done) done_cnt++;
   end
   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask
   task automatic vsync();
      c_vsync = 1'b1;
      tick(3);
      c_vsync = 1'b0;
      tick(3);
   endtask
   // Even bytes carry the line tag, odd bytes the pixel index, so 444 output reads {tag[3:0], px}.
   task automatic line(input int nb, input logic [7:0] tag);
      for (int i = 0; i < nb; i++) begin
         href = 1'b1;
         data = i[0] ? 8'(i / 2) : tag;
         tick(1);
      end
      href = 1'b0;
      data = '0;
      tick(4);
   endtask
   task automatic frame(input int nl, input int nb);
      vsync();
      for (int l = 0; l < nl; l++) line(nb, 8'(l));
   endtask
   task automatic cap();
      cap_req = 1'b1;
      tick(1);
      cap_req = 1'b0;
      tick(1);
   endtask
   task automatic window(input int vs, input int hs, input int w, input int h, input int dec, input int f);
      v_start = CNT_W'(vs);
      h_start = CNT_W'(hs);
      out_w   = (AW_H+1)'(w);
      out_h   = (AW_V+1)'(h);
      decim   = 2'(dec);
      fmt     = 2'(f);
   endtask
   task automatic test_reset();
      tick(3);
      checks++;
      if ({wea, addra, dina, cap_busy, cap_done, frame_cnt, phase_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h required 0", {wea, addra, dina, cap_busy, cap_done, frame_cnt, phase_err});
      end
      rstb = 1'b1;
      tick(3);
      checks++;
      if (wea !== 1'b0 || cap_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got wea=%b busy=%b required 0 0", wea, cap_busy);
      end
   endtask
   task automatic test_window(input int dec);
      int b, d, s;
      logic [EW-1:0] got, e;
      b = wq.size();
      d = done_cnt;
      window(4, 8, 4, 2, dec, 0);
      cap();
      checks++;
      if (cap_busy !== 1'b1) begin
         errors++;
         $display("FAIL win%0d_busy_arm got %b required 1", dec, cap_busy);
      end
      frame(16, 64);
      checks++;
      if (done_cnt != d || cap_busy !== 1'b1) begin
         errors++;
         $display("FAIL win%0d_mid got done=%0d busy=%b required done=%0d busy=1", dec, done_cnt, cap_busy, d);
      end
      frame(16, 64);
      exp_fc++;
      s = wq.size() - b;
      checks++;
      if (s != 8) begin
         errors++;
         $display("FAIL win%0d_count got %0d required 8", dec, s);
      end
      for (int k = 0; k < 8; k++) begin
         e = {14'((k / 4) * 128 + k % 4), 4'(4 + (k / 4) * (dec + 1)), 8'(8 + (k % 4) * (dec + 1))};
         got = (b + k < wq.size()) ? wq[b + k] : 'x;
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL win%0d_write%0d got %h required %h", dec, k, got, e);
         end
      end
      checks++;
      if (done_cnt - d != 1 || frame_cnt !== 8'(exp_fc) || cap_busy !== 1'b0) begin
         errors++;
         $display("FAIL win%0d_end got done=%0d fc=%0d busy=%b required 1 %0d 0", dec, done_cnt - d, frame_cnt, cap_busy, exp_fc);
      end
   endtask
   task automatic test_cont();
      int b, d;
      logic [EW-1:0] e;
      b = wq.size();
      d = done_cnt;
      window(4, 8, 4, 2, 0, 0);
      cont_en = 1'b1;
      cap();
      for (int f = 0; f < 4; f++) begin
         frame(8, 64);
         checks++;
         if (cap_busy !== 1'b1 || done_cnt != d) begin
            errors++;
            $display("FAIL cont_frame%0d got busy=%b done=%0d required 1 %0d", f, cap_busy, done_cnt, d);
         end
      end
      checks++;
      if (frame_cnt !== 8'(exp_fc + 3)) begin
         errors++;
         $display("FAIL cont_fc3 got %0d required %0d", frame_cnt, exp_fc + 3);
      end
      cont_en = 1'b0;
      frame(8, 64);
      exp_fc += 4;
      checks++;
      if (done_cnt - d != 1 || frame_cnt !== 8'(exp_fc) || cap_busy !== 1'b0) begin
         errors++;
         $display("FAIL cont_end got done=%0d fc=%0d busy=%b required 1 %0d 0", done_cnt - d, frame_cnt, cap_busy, exp_fc);
      end
      e = {14'(131), 4'h5, 8'h0B};
      checks++;
      if (wq.size() - b != 32 || wq[wq.size() - 1] !== e) begin
         errors++;
         $display("FAIL cont_writes got n=%0d last=%h required n=32 last=%h", wq.size() - b, wq[wq.size() - 1], e);
      end
   endtask
   task automatic test_pack();
      logic [1:0]  tf[4] = '{2'd1, 2'd2, 2'd0, 2'd3};
      logic [7:0]  t0[4] = '{8'hF8, 8'hA5, 8'h0C, 8'hFF};
      logic [7:0]  t1[4] = '{8'h1F, 8'h00, 8'h5A, 8'hFF};
      logic [11:0] te[4] = '{12'hF0F, 12'hAAA, 12'hC5A, 12'h000};
      for (int k = 0; k < 4; k++) begin
         window(0, 0, 1, 1, 0, int'(tf[k]));
         cap();
         vsync();
         href = 1'b1;
         data = t0[k];
         tick(1);
         data = t1[k];
         tick(1);
         href = 1'b0;
         data = '0;
         checks++;
         if (wea !== 1'b0) begin
            errors++;
            $display("FAIL pack%0d_early got wea=%b required 0", k, wea);
         end
         tick(1);
         checks++;
         if (wea !== 1'b1 || addra !== '0 || dina !== te[k]) begin
            errors++;
            $display("FAIL pack%0d_write got wea=%b addr=%h dina=%h required 1 0 %h", k, wea, addra, dina, te[k]);
         end
         tick(1);
         checks++;
         if (wea !== 1'b0 || dina !== te[k]) begin
            errors++;
            $display("FAIL pack%0d_hold got wea=%b dina=%h required 0 %h", k, wea, dina, te[k]);
         end
         tick(3);
         vsync();
         exp_fc++;
      end
      checks++;
      if (frame_cnt !== 8'(exp_fc)) begin
         errors++;
         $display("FAIL pack_fc got %0d required %0d", frame_cnt, exp_fc);
      end
   endtask
   task automatic test_phase();
      int b;
      logic [EW-1:0] ex[3], got;
      ex = '{{14'(0), 12'h00E}, {14'(128), 12'h10E}, {14'(129), 12'h10F}};
      b = wq.size();
      window(0, 14, 4, 2, 0, 0);
      cap();
      checks++;
      if (phase_err !== 1'b0) begin
         errors++;
         $display("FAIL phase_clear0 got %b required 0", phase_err);
      end
      vsync();
      line(31, 8'd0);
      checks++;
      if (phase_err !== 1'b1) begin
         errors++;
         $display("FAIL phase_set got %b required 1", phase_err);
      end
      line(32, 8'd1);
      vsync();
      exp_fc++;
      checks++;
      if (phase_err !== 1'b1 || wq.size() - b != 3) begin
         errors++;
         $display("FAIL phase_sticky got perr=%b n=%0d required 1 3", phase_err, wq.size() - b);
      end
      for (int k = 0; k < 3; k++) begin
         got = (b + k < wq.size()) ? wq[b + k] : 'x;
         checks++;
         if (got !== ex[k]) begin
            errors++;
            $display("FAIL phase_write%0d got %h required %h", k, got, ex[k]);
         end
      end
      cap();
      checks++;
      if (phase_err !== 1'b0) begin
         errors++;
         $display("FAIL phase_reqclr got %b required 0", phase_err);
      end
   endtask
   task automatic test_reset_mid();
      int b;
      b = wq.size();
      window(0, 0, 16, 4, 0, 0);
      cap();
      vsync();
      for (int i = 0; i < 10; i++) begin
         href = 1'b1;
         data = i[0] ? 8'(i / 2) : 8'h00;
         tick(1);
      end
      checks++;
      if (wq.size() - b < 3) begin
         errors++;
         $display("FAIL rmid_prewrites got %0d required >=3", wq.size() - b);
      end
      rstb = 1'b0;
      tick(1);
      exp_fc = 0;
      checks++;
      if ({wea, addra, dina, cap_busy, cap_done, frame_cnt, phase_err} !== '0) begin
         errors++;
         $display("FAIL rmid_outputs got %h required 0", {wea, addra, dina, cap_busy, cap_done, frame_cnt, phase_err});
      end
      rstb = 1'b1;
      b = wq.size();
      for (int i = 10; i < 20; i++) begin
         data = i[0] ? 8'(i / 2) : 8'h00;
         tick(1);
      end
      href = 1'b0;
      tick(4);
      line(32, 8'd1);
      vsync();
      line(32, 8'd0);
      checks++;
      if (wq.size() != b || cap_busy !== 1'b0 || frame_cnt !== 8'(exp_fc)) begin
         errors++;
         $display("FAIL rmid_quiet got n=%0d busy=%b fc=%0d required 0 0 0", wq.size() - b, cap_busy, frame_cnt);
      end
   endtask
   initial begin
      test_reset();
      test_window(0);
      test_window(1);
      test_cont();
      test_pack();
      test_phase();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
